// File: rtl/gp_to_fp_unit_sp_pkg.sv
// Shared types and FloPoCo constants for the GP-to-FP conversion unit.
// cva5_types holds issue-side types; gp_to_fp_unit_sp_pkg holds FPU constants.
package cva5_types;

   localparam int ID_W = 3;

   typedef logic [ID_W-1:0] id_t;

   typedef enum logic [1:0] {
      FPCVT_FROM_I_OP = 2'd0,
      FPCVT_FROM_U_OP = 2'd1,
      FP_FROM_IEEE_OP = 2'd2
   } gp_to_fp_op_t;

   typedef struct packed {
      logic [31:0]  rs1;
      gp_to_fp_op_t op;
   } gp_to_fp_inputs_t;

endpackage

package gp_to_fp_unit_sp_pkg;

   localparam int FLOPOCO_W = 34;

   localparam logic [1:0] FLOPOCO_ZERO   = 2'b00;
   localparam logic [1:0] FLOPOCO_NORMAL = 2'b01;
   localparam logic [1:0] FLOPOCO_INF    = 2'b10;
   localparam logic [1:0] FLOPOCO_NAN    = 2'b11;

   localparam int FP_BIAS = 127;

   // Exponent of a 32-bit integer whose MSB lands on bit 31 (lz = 0)
   localparam logic [7:0] EXP_MAX_INT = 8'(FP_BIAS + 31);

   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/gp_to_fp_unit_sp_if.sv
// Issue and writeback handshake interfaces used by execution units.
// The unit modport is the execution-unit side of each bundle.
interface unit_issue_interface;
   import cva5_types::*;

   logic new_request;
   id_t  id;
   logic ready;

   modport unit (input new_request, input id, output ready);
   modport decode (output new_request, output id, input ready);
endinterface

interface unit_writeback_interface;
   import cva5_types::*;
   import gp_to_fp_unit_sp_pkg::*;

   logic [FLOPOCO_W-1:0] rd;
   id_t                  id;
   logic                 done;
   logic                 ack;

   modport unit (output rd, output id, output done, input ack);
   modport wb (input rd, input id, input done, output ack);
endinterface

// File: rtl/gp_to_fp_unit_sp_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input yields 32.
// Scanning upward lets the highest set bit win.
module lzc32 (
   input  logic [31:0] a_i,
   output logic [5:0]  lz_o
);

   always_comb begin
      lz_o = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (a_i[i])
            lz_o = 6'(31 - i);
      end
   end

endmodule

// File: rtl/gp_to_fp_unit_sp.sv
// Two-stage int/IEEE to FloPoCo SP converter with full backpressure.
// Optional fflags output enabled by GP_TO_FP_FLAGS_EN.
module gp_to_fp_unit_sp
   import cva5_types::*;
   import gp_to_fp_unit_sp_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  gp_to_fp_inputs_t      inputs,
   unit_issue_interface.unit     issue,
   unit_writeback_interface.unit wb
`ifdef GP_TO_FP_FLAGS_EN
   ,
   output logic [4:0]            fflags
`endif
);

   logic adv2;
   logic en1;

   logic                 v1_q;
   id_t                  id1_q;
   gp_to_fp_op_t         op1_q;
   logic                 sign1_q;
   logic [31:0]          data1_q;
   logic [5:0]           lz1_q;

   logic                 v2_q;
   id_t                  id2_q;
   logic [FLOPOCO_W-1:0] rd2_q;

   assign adv2 = !v2_q || wb.ack;
   assign en1  = !v1_q || adv2;

   assign issue.ready = en1;
   assign wb.done     = v2_q;
   assign wb.id       = id2_q;
   assign wb.rd       = rd2_q;

   logic        sign_d;
   logic [31:0] mag;
   logic [5:0]  lz_d;
   logic [31:0] norm;
   logic [31:0] data1_d;

   always_comb begin
      sign_d = 1'b0;
      mag    = inputs.rs1;
      unique case (inputs.op)
         FPCVT_FROM_I_OP: begin
            sign_d = inputs.rs1[31];
            mag    = abs32(inputs.rs1);
         end
         FPCVT_FROM_U_OP: begin
            sign_d = 1'b0;
            mag    = inputs.rs1;
         end
         default: begin
            sign_d = 1'b0;
            mag    = inputs.rs1;
         end
      endcase
   end

   lzc32 u_lzc (
      .a_i  (mag),
      .lz_o (lz_d)
   );

   assign norm = mag << lz_d;

   // IEEE sources skip normalization and carry their raw bits forward
   assign data1_d = (inputs.op == FP_FROM_IEEE_OP) ? inputs.rs1 : norm;

   logic        is_ieee1;
   logic        int_zero;
   logic [22:0] frac;
   logic        g;
   logic        s;
   logic        up;
   logic        carry;
   logic [22:0] frac_r;
   logic [7:0]  exp_i;
   logic [FLOPOCO_W-1:0] rd_int;

   assign is_ieee1 = (op1_q == FP_FROM_IEEE_OP);

   // lz reaches 32 only for a zero magnitude
   assign int_zero = lz1_q[5];
   assign frac     = data1_q[30:8];
   assign g        = data1_q[7];
   assign s        = |data1_q[6:0];
   assign up       = g && (s || frac[0]);

   assign {carry, frac_r} = {1'b0, frac} + 24'(up);
   assign exp_i = EXP_MAX_INT - {2'b00, lz1_q} + {7'd0, carry};

   assign rd_int = int_zero ? '0
                 : {FLOPOCO_NORMAL, sign1_q, exp_i, frac_r};

   logic [7:0]  e;
   logic [22:0] f;
   logic        e_max;
   logic        e_zero;
   logic        f_zero;
   logic [FLOPOCO_W-1:0] rd_ieee;

   assign e      = data1_q[30:23];
   assign f      = data1_q[22:0];
   assign e_max  = (e == 8'hFF);
   assign e_zero = (e == 8'h00);
   assign f_zero = (f == 23'd0);

   always_comb begin
      rd_ieee = {FLOPOCO_NORMAL, data1_q};
      unique case (1'b1)
         e_max && f_zero:  rd_ieee = {FLOPOCO_INF, data1_q};
         e_max && !f_zero: rd_ieee = {FLOPOCO_NAN, data1_q};
         e_zero:           rd_ieee = {FLOPOCO_ZERO, data1_q[31], 31'd0};
         default:          rd_ieee = {FLOPOCO_NORMAL, data1_q};
      endcase
   end

   logic [FLOPOCO_W-1:0] rd2_d;

   assign rd2_d = is_ieee1 ? rd_ieee : rd_int;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         if (en1)
            v1_q <= issue.new_request;
         if (adv2)
            v2_q <= v1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (en1) begin
         id1_q   <= issue.id;
         op1_q   <= inputs.op;
         sign1_q <= sign_d;
         data1_q <= data1_d;
         lz1_q   <= lz_d;
      end
      if (adv2) begin
         id2_q <= id1_q;
         rd2_q <= rd2_d;
      end
   end

`ifdef GP_TO_FP_FLAGS_EN
   logic       uf_d;
   logic       nx_d;
   logic [4:0] flags2_q;

   always_comb begin
      uf_d = 1'b0;
      nx_d = 1'b0;
      if (is_ieee1) begin
         uf_d = e_zero && !f_zero;
         nx_d = e_zero && !f_zero;
      end else begin
         nx_d = !int_zero && (g || s);
      end
   end

   always_ff @(posedge clk) begin
      if (adv2)
         flags2_q <= {3'b000, uf_d, nx_d};
   end

   assign fflags = flags2_q;
`endif

endmodule

// File: tb/tb_gp_to_fp_unit_sp.sv
// Directed-vector bench for gp_to_fp_unit_sp: conversions, stalls, reset.
// Flag comparisons are compiled in only with GP_TO_FP_FLAGS_EN.
module tb_gp_to_fp_unit_sp;
   import cva5_types::*;

   logic             clk;
   logic             rst;
   gp_to_fp_inputs_t inputs;

   unit_issue_interface     issue_if ();
   unit_writeback_interface wb_if ();

`ifdef GP_TO_FP_FLAGS_EN
   logic [4:0] fflags;
`endif

   gp_to_fp_unit_sp dut (
      .clk    (clk),
      .rst    (rst),
      .inputs (inputs),
      .issue  (issue_if),
      .wb     (wb_if)
`ifdef GP_TO_FP_FLAGS_EN
      ,
      .fflags (fflags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [33:0] got_rd;
   logic [4:0]  got_fl;
   logic        got_ok;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one op with ack held high and captures the result it returns.
   task automatic run_op(input gp_to_fp_op_t op, input logic [31:0] rs1,
                         input id_t id);
      got_ok = 1'b0;
      got_rd = '0;
      got_fl = '0;
      inputs.op = op;
      inputs.rs1 = rs1;
      issue_if.id = id;
      issue_if.new_request = 1'b1;
      @(posedge clk);
      #1;
      issue_if.new_request = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (wb_if.done) begin
            got_ok = 1'b1;
            got_rd = wb_if.rd;
`ifdef GP_TO_FP_FLAGS_EN
            got_fl = fflags;
`endif
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      issue_if.new_request = 1'b0;
      issue_if.id = '0;
      inputs = '0;
      wb_if.ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++;
      if (wb_if.done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_done: got %b want 0", wb_if.done);
      end
      n_cmp++;
      if (issue_if.ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b want 1", issue_if.ready);
      end
   endtask

   task automatic test_from_int();
      logic [31:0] src [4];
      logic [33:0] exp_rd [4];
      logic [4:0]  exp_fl [4];
      src    = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h80000000};
      exp_rd = '{34'h1_3F800000, 34'h0_00000000,
                 34'h1_BF800000, 34'h1_CF000000};
      exp_fl = '{5'd0, 5'd0, 5'd0, 5'd0};
      for (int i = 0; i < 4; i++) begin
         run_op(FPCVT_FROM_I_OP, src[i], id_t'(i));
         n_cmp++;
         if (!got_ok || got_rd !== exp_rd[i]) begin
            n_err++;
            $display("FAIL from_i[%0d] src=%h: got %h ok=%b want %h",
                     i, src[i], got_rd, got_ok, exp_rd[i]);
         end
`ifdef GP_TO_FP_FLAGS_EN
         n_cmp++;
         if (got_fl !== exp_fl[i]) begin
            n_err++;
            $display("FAIL from_i_flags[%0d]: got %b want %b",
                     i, got_fl, exp_fl[i]);
         end
`else
         exp_fl[i] = 5'd0;
`endif
      end
   endtask

   task automatic test_from_uint();
      logic [31:0] src [4];
      logic [33:0] exp_rd [4];
      logic [4:0]  exp_fl [4];
      src    = '{32'hFFFFFFFF, 32'h01000001, 32'h00000003, 32'h00000000};
      exp_rd = '{34'h1_4F800000, 34'h1_4B800000,
                 34'h1_40400000, 34'h0_00000000};
      exp_fl = '{5'b00001, 5'b00001, 5'd0, 5'd0};
      for (int i = 0; i < 4; i++) begin
         run_op(FPCVT_FROM_U_OP, src[i], id_t'(i + 4));
         n_cmp++;
         if (!got_ok || got_rd !== exp_rd[i]) begin
            n_err++;
            $display("FAIL from_u[%0d] src=%h: got %h ok=%b want %h",
                     i, src[i], got_rd, got_ok, exp_rd[i]);
         end
`ifdef GP_TO_FP_FLAGS_EN
         n_cmp++;
         if (got_fl !== exp_fl[i]) begin
            n_err++;
            $display("FAIL from_u_flags[%0d]: got %b want %b",
                     i, got_fl, exp_fl[i]);
         end
`else
         exp_fl[i] = 5'd0;
`endif
      end
   endtask

   task automatic test_from_ieee();
      logic [31:0] src [4];
      logic [33:0] exp_rd [4];
      logic [4:0]  exp_fl [4];
      src    = '{32'h7F800000, 32'h7FC00000, 32'h80000001, 32'h3F800000};
      exp_rd = '{34'h2_7F800000, 34'h3_7FC00000,
                 34'h0_80000000, 34'h1_3F800000};
      exp_fl = '{5'd0, 5'd0, 5'b00011, 5'd0};
      for (int i = 0; i < 4; i++) begin
         run_op(FP_FROM_IEEE_OP, src[i], id_t'(i));
         n_cmp++;
         if (!got_ok || got_rd !== exp_rd[i]) begin
            n_err++;
            $display("FAIL from_ieee[%0d] src=%h: got %h ok=%b want %h",
                     i, src[i], got_rd, got_ok, exp_rd[i]);
         end
`ifdef GP_TO_FP_FLAGS_EN
         n_cmp++;
         if (got_fl !== exp_fl[i]) begin
            n_err++;
            $display("FAIL from_ieee_flags[%0d]: got %b want %b",
                     i, got_fl, exp_fl[i]);
         end
`else
         exp_fl[i] = 5'd0;
`endif
      end
   endtask

   task automatic test_back_to_back();
      id_t         ids [$];
      logic [33:0] rds [$];
      logic [33:0] held;
      id_t         exp_id [3];
      logic [33:0] exp_rd [3];
      exp_id = '{3'd1, 3'd2, 3'd3};
      exp_rd = '{34'h1_3F800000, 34'h1_40000000, 34'h1_C0000000};
      wb_if.ack = 1'b0;
      inputs.op = FPCVT_FROM_I_OP;
      inputs.rs1 = 32'h00000001;
      issue_if.id = 3'd1;
      issue_if.new_request = 1'b1;
      @(posedge clk);
      #1;
      inputs.op = FPCVT_FROM_U_OP;
      inputs.rs1 = 32'h00000002;
      issue_if.id = 3'd2;
      @(posedge clk);
      #1;
      inputs.op = FPCVT_FROM_I_OP;
      inputs.rs1 = 32'hFFFFFFFE;
      issue_if.id = 3'd3;
      n_cmp++;
      if (issue_if.ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_ready_low: got %b want 0", issue_if.ready);
      end
      n_cmp++;
      if (wb_if.done !== 1'b1 || wb_if.id !== 3'd1) begin
         n_err++;
         $display("FAIL bp_head: got done=%b id=%0d want done=1 id=1",
                  wb_if.done, wb_if.id);
      end
      held = wb_if.rd;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (wb_if.rd !== held || wb_if.id !== 3'd1 || wb_if.done !== 1'b1) begin
         n_err++;
         $display("FAIL bp_hold: got rd=%h id=%0d want rd=%h id=1",
                  wb_if.rd, wb_if.id, held);
      end
      n_cmp++;
      if (held !== 34'h1_3F800000) begin
         n_err++;
         $display("FAIL bp_held_value: got %h want %h", held, 34'h1_3F800000);
      end
      wb_if.ack = 1'b1;
      #1;
      n_cmp++;
      if (issue_if.ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_ready_on_ack: got %b want 1", issue_if.ready);
      end
      for (int c = 0; c < 8; c++) begin
         if (wb_if.done) begin
            ids.push_back(wb_if.id);
            rds.push_back(wb_if.rd);
         end
         @(posedge clk);
         #1;
         issue_if.new_request = 1'b0;
      end
      n_cmp++;
      if (ids.size() != 3) begin
         n_err++;
         $display("FAIL bp_count: got %0d want 3", ids.size());
      end
      for (int i = 0; i < 3 && i < ids.size(); i++) begin
         n_cmp++;
         if (ids[i] !== exp_id[i] || rds[i] !== exp_rd[i]) begin
            n_err++;
            $display("FAIL bp_order[%0d]: got id=%0d rd=%h want id=%0d rd=%h",
                     i, ids[i], rds[i], exp_id[i], exp_rd[i]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      int n_done;
      n_done = 0;
      wb_if.ack = 1'b0;
      inputs.op = FPCVT_FROM_U_OP;
      inputs.rs1 = 32'h00000005;
      issue_if.id = 3'd5;
      issue_if.new_request = 1'b1;
      @(posedge clk);
      #1;
      issue_if.id = 3'd6;
      @(posedge clk);
      #1;
      issue_if.new_request = 1'b0;
      n_cmp++;
      if (wb_if.done !== 1'b1 || issue_if.ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_full: got done=%b ready=%b want 1/0",
                  wb_if.done, issue_if.ready);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++;
      if (wb_if.done !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_done: got %b want 0", wb_if.done);
      end
      n_cmp++;
      if (issue_if.ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_ready: got %b want 1", issue_if.ready);
      end
      wb_if.ack = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (wb_if.done)
            n_done++;
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (n_done != 0) begin
         n_err++;
         $display("FAIL rst_mid_stale: got %0d done cycles want 0", n_done);
      end
   endtask

   initial begin
      test_reset();
      test_from_int();
      test_from_uint();
      test_from_ieee();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
